vip_featuremap_conv2d_scheduler: RTL and testbench

- Frame-level controller for a bank of NUM_FILTERS conv2d filter cores that share one 8-channel input feature-map stream.
- LOAD phase: broadcasts each 8-channel pixel vector into every filter's input FIFOs, stalling while any filter is full.
- COLLECT phase: drains each filter's output FIFO in turn (filter 0 first), FRAME_PIXELS words each, onto one serial result stream.
- Sits between the feature-map source / DMA and the per-filter conv2d top blocks.

---
 rtl/vip_featuremap_conv2d_scheduler.sv | 178 +++++++++++++++++
 tb/tb_vip_featuremap_conv2d_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_featuremap_conv2d_scheduler.sv
// Frame scheduler for a bank of conv2d filter cores: broadcasts one frame of
// pixel vectors to every filter, then drains each filter's results in turn.
module vip_featuremap_conv2d_scheduler #(
    parameter int DWIDTH       = 32,
    parameter int NUM_CH       = 8,
    parameter int NUM_FILTERS  = 4,
    parameter int FRAME_PIXELS = 12544,
    parameter int CNT_W        = 14,
    parameter int FSEL_W       = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH*DWIDTH-1:0]      src_data,
    input  logic                          src_valid,
    output logic                          src_ready,
    output logic [NUM_CH*DWIDTH-1:0]      flt_in_data,
    output logic                          flt_in_wrreq,
    input  logic [NUM_FILTERS-1:0]        flt_in_full,
    input  logic [NUM_FILTERS*DWIDTH-1:0] flt_out_data,
    input  logic [NUM_FILTERS-1:0]        flt_out_empty,
    output logic [NUM_FILTERS-1:0]        flt_out_rdreq,
    output logic [DWIDTH-1:0]             dst_data,
    output logic                          dst_valid,
    input  logic                          dst_ready,
    output logic [FSEL_W-1:0]             filter_sel,
    output logic                          busy,
    output logic                          frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
    logic [FSEL_W-1:0]   filter_sel_q, filter_sel_d;
    logic [DWIDTH-1:0]   dst_data_q, dst_data_d;
    logic                dst_valid_q, dst_valid_d;
    logic                frame_done_q, frame_done_d;

    logic [DWIDTH-1:0]      sel_data_s;
    logic                   sel_empty_s;
    logic                   src_ready_s;
    logic                   accept_s;
    logic                   pop_s;
    logic                   pix_last_s;
    logic                   res_last_s;
    logic                   sel_last_s;
    logic [NUM_FILTERS-1:0] rdreq_s;

    // Select the filter currently being drained and derive the handshakes.
    // Reset gates the strobes so nothing reaches the filters while held.
    always_comb begin
        sel_data_s  = {DWIDTH{1'b0}};
        sel_empty_s = 1'b1;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            if (FSEL_W'(f) == filter_sel_q) begin
                sel_data_s  = flt_out_data[f*DWIDTH +: DWIDTH];
                sel_empty_s = flt_out_empty[f];
            end else begin
                sel_data_s  = sel_data_s;
                sel_empty_s = sel_empty_s;
            end
        end
        src_ready_s = reset & (state_q == ST_LOAD) & ~(|flt_in_full);
        accept_s    = src_valid & src_ready_s;
        pop_s       = reset & (state_q == ST_COLLECT) & ~sel_empty_s
                      & (~dst_valid_q | dst_ready);
        pix_last_s  = (pix_cnt_q == CNT_W'(FRAME_PIXELS - 1));
        res_last_s  = (res_cnt_q == CNT_W'(FRAME_PIXELS - 1));
        sel_last_s  = (filter_sel_q == FSEL_W'(NUM_FILTERS - 1));
        for (int f = 0; f < NUM_FILTERS; f++) begin
            rdreq_s[f] = pop_s & (FSEL_W'(f) == filter_sel_q);
        end
    end

    // Next-state logic for the frame FSM, counters and result register.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        res_cnt_d    = res_cnt_q;
        filter_sel_d = filter_sel_q;
        dst_data_d   = dst_data_q;
        dst_valid_d  = dst_valid_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (src_valid) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    if (pix_last_s) begin
                        pix_cnt_d    = {CNT_W{1'b0}};
                        res_cnt_d    = {CNT_W{1'b0}};
                        filter_sel_d = {FSEL_W{1'b0}};
                        state_d      = ST_COLLECT;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    end
                end else begin
                    pix_cnt_d = pix_cnt_q;
                end
            end
            ST_COLLECT: begin
                if (pop_s) begin
                    dst_data_d  = sel_data_s;
                    dst_valid_d = 1'b1;
                    if (res_last_s) begin
                        res_cnt_d = {CNT_W{1'b0}};
                        if (sel_last_s) begin
                            state_d = ST_FLUSH;
                        end else begin
                            filter_sel_d = filter_sel_q + FSEL_W'(1);
                        end
                    end else begin
                        res_cnt_d = res_cnt_q + CNT_W'(1);
                    end
                end else if (dst_valid_q & dst_ready) begin
                    dst_valid_d = 1'b0;
                end else begin
                    dst_valid_d = dst_valid_q;
                end
            end
            ST_FLUSH: begin
                if (~dst_valid_q | dst_ready) begin
                    dst_valid_d  = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state, counters and registered result outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= {CNT_W{1'b0}};
            res_cnt_q    <= {CNT_W{1'b0}};
            filter_sel_q <= {FSEL_W{1'b0}};
            dst_data_q   <= {DWIDTH{1'b0}};
            dst_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            res_cnt_q    <= res_cnt_d;
            filter_sel_q <= filter_sel_d;
            dst_data_q   <= dst_data_d;
            dst_valid_q  <= dst_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign src_ready     = src_ready_s;
    assign flt_in_data   = src_data;
    assign flt_in_wrreq  = accept_s;
    assign flt_out_rdreq = rdreq_s;
    assign dst_data      = dst_data_q;
    assign dst_valid     = dst_valid_q;
    assign filter_sel    = filter_sel_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_vip_featuremap_conv2d_scheduler.sv
// Bench for the conv2d frame scheduler: small frame, queue-modelled filter
// FIFOs, scoreboarded broadcast and result order.
module tb_vip_featuremap_conv2d_scheduler;

    localparam int DW = 32;
    localparam int NCH = 8;
    localparam int NF = 2;
    localparam int FP = 4;
    localparam int CW = 3;
    localparam int FW = 1;
    localparam int VW = NCH * DW;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [VW-1:0]    src_data = '0;
    logic             src_valid = 1'b0;
    logic             src_ready;
    logic [VW-1:0]    flt_in_data;
    logic             flt_in_wrreq;
    logic [NF-1:0]    flt_in_full = '0;
    logic [NF*DW-1:0] flt_out_data = '0;
    logic [NF-1:0]    flt_out_empty = '1;
    logic [NF-1:0]    flt_out_rdreq;
    logic [DW-1:0]    dst_data;
    logic             dst_valid;
    logic             dst_ready = 1'b0;
    logic [FW-1:0]    filter_sel;
    logic             busy;
    logic             frame_done;

    always #5 clock = ~clock;

    vip_featuremap_conv2d_scheduler #(
        .DWIDTH(DW), .NUM_CH(NCH), .NUM_FILTERS(NF),
        .FRAME_PIXELS(FP), .CNT_W(CW), .FSEL_W(FW)
    ) dut (
        .clock(clock), .reset(reset),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .flt_in_data(flt_in_data), .flt_in_wrreq(flt_in_wrreq),
        .flt_in_full(flt_in_full), .flt_out_data(flt_out_data),
        .flt_out_empty(flt_out_empty), .flt_out_rdreq(flt_out_rdreq),
        .dst_data(dst_data), .dst_valid(dst_valid), .dst_ready(dst_ready),
        .filter_sel(filter_sel), .busy(busy), .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] fq [NF][$];
    logic [VW-1:0] src_vecs [$];
    logic [DW-1:0] exp_out [$];
    logic [NF-1:0] hide = '0;

    task automatic check_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifos();
        for (int f = 0; f < NF; f++) begin
            flt_out_data[f*DW +: DW] = (fq[f].size() > 0) ? fq[f][0] : '0;
            flt_out_empty[f] = (fq[f].size() == 0) || hide[f];
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_src_ready"}, src_ready, 0);
        check_val({tag, "_dst_valid"}, dst_valid, 0);
        check_val({tag, "_rdreq"}, flt_out_rdreq, 0);
        check_val({tag, "_done"}, frame_done, 0);
    endtask

    // mode 0: ideal flow; mode 1: directed full / dst_ready stalls; mode 2: random
    task automatic run_frame(input int mode, input int abort_at);
        int accepted = 0, consumed = 0, pops = 0, done_cnt = 0, cyc = 0;
        int first_wr = -1, last_wr = -1, first_rd = -1, last_rd = -1;
        int full_left = 0, rdy_left = 0, ef;
        bit full_armed = 1'b1, rdy_armed = 1'b1, fin = 1'b0, saw_wr;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [NF-1:0] pend_pop;
        logic [VW-1:0] v;
        logic [DW-1:0] w;

        src_vecs.delete();
        exp_out.delete();
        for (int p = 0; p < FP; p++) begin
            for (int k = 0; k < NCH; k++) begin
                v[k*DW +: DW] = (mode == 0) ? DW'(16 * p + k) : DW'($urandom());
            end
            src_vecs.push_back(v);
        end
        for (int f = 0; f < NF; f++) begin
            fq[f].delete();
            for (int p = 0; p < FP; p++) begin
                w = DW'($urandom());
                fq[f].push_back(w);
                exp_out.push_back(w);
            end
        end
        src_valid = 1'b1;
        src_data = src_vecs[0];
        flt_in_full = '0;
        dst_ready = 1'b1;
        hide = '0;
        drive_fifos();

        while (!fin && cyc < 400) begin
            @(negedge clock);
            saw_wr = flt_in_wrreq;
            if (flt_in_wrreq) begin
                if (accepted < FP) check_val("bcast_data", flt_in_data, src_vecs[accepted]);
                else check_val("extra_wrreq", 1, 0);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                accepted++;
            end
            if (|flt_in_full) begin
                check_val("stall_ready", src_ready, 0);
                check_val("stall_wrreq", flt_in_wrreq, 0);
            end
            pend_pop = flt_out_rdreq;
            if (pend_pop != '0) begin
                ef = pops / FP;
                check_val("rdreq_filter", pend_pop, 1 << ef);
                check_val("filter_sel", filter_sel, ef);
                check_val("pop_empty", |(pend_pop & flt_out_empty), 0);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                pops++;
            end
            if (dst_valid && !dst_ready) check_val("stall_no_rdreq", flt_out_rdreq, 0);
            if (prev_stall) begin
                check_val("hold_valid", dst_valid, 1);
                check_val("hold_data", dst_data, prev_data);
            end
            if (dst_valid && dst_ready) begin
                if (exp_out.size() > 0) check_val("dst_data", dst_data, exp_out.pop_front());
                else check_val("extra_dst", 1, 0);
                consumed++;
            end
            prev_stall = dst_valid & ~dst_ready;
            prev_data = dst_data;
            if (frame_done) begin
                done_cnt++;
                check_val("done_after_all", consumed, NF * FP);
                fin = 1'b1;
            end
            if (abort_at > 0 && consumed == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check_idle_outputs("abort");
                check_val("abort_wrreq", flt_in_wrreq, 0);
                check_val("abort_fsel", filter_sel, 0);
                src_valid = 1'b0;
                hide = '0;
                for (int f = 0; f < NF; f++) fq[f].delete();
                drive_fifos();
                @(posedge clock);
                @(posedge clock);
                #1 reset = 1'b1;
                return;
            end

            @(posedge clock);
            #1;
            for (int f = 0; f < NF; f++) begin
                if (pend_pop[f] && fq[f].size() > 0) void'(fq[f].pop_front());
            end
            if (accepted < FP) begin
                src_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                src_data = src_vecs[accepted];
            end else begin
                src_valid = (consumed < NF * FP - 1) ? ((mode == 2) ? 1'($urandom()) : 1'b1) : 1'b0;
                src_data = {NCH{DW'($urandom())}};
            end
            if (mode == 1 && full_armed && accepted >= 1 && saw_wr) begin
                full_armed = 1'b0;
                full_left = 3;
            end
            if (mode == 1) begin
                flt_in_full = (full_left > 0) ? 2'b10 : 2'b00;
                if (full_left > 0) full_left--;
            end else if (mode == 2) begin
                flt_in_full = NF'($urandom_range(0, 3)) & NF'($urandom_range(0, 3));
            end else begin
                flt_in_full = '0;
            end
            if (mode == 1 && rdy_armed && consumed >= 3) begin
                rdy_armed = 1'b0;
                rdy_left = 5;
            end
            if (mode == 1) begin
                dst_ready = (rdy_left == 0);
                if (rdy_left > 0) rdy_left--;
            end else if (mode == 2) begin
                dst_ready = 1'($urandom());
                hide = NF'($urandom_range(0, 3)) & NF'($urandom_range(0, 3));
            end else begin
                dst_ready = 1'b1;
            end
            drive_fifos();
            cyc++;
        end

        check_val("frame_timeout", fin, 1);
        check_val("accepted_cnt", accepted, FP);
        check_val("consumed_cnt", consumed, NF * FP);
        check_val("done_cnt", done_cnt, 1);
        if (mode == 0) begin
            check_val("wr_consecutive", last_wr - first_wr, FP - 1);
            check_val("rd_consecutive", last_rd - first_rd, NF * FP - 1);
        end
        src_valid = 1'b0;
        @(negedge clock);
        check_idle_outputs("post_frame");
    endtask

    initial begin
        reset = 1'b0;
        drive_fifos();
        #12;
        check_idle_outputs("in_reset");
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check_idle_outputs("after_reset");

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(0, 2);
        @(negedge clock);
        check_idle_outputs("after_abort");
        run_frame(0, 0);
        for (int i = 0; i < 6; i++) run_frame(2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
